// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared constants and state encoding for the boot-loading
// instruction memory (imem_boot / imem_ram).
package imem_boot_pkg;

  localparam int unsigned WORD_LEN = 32;

  // Byte address of instruction word 0 as seen by the core fetch stage.
  localparam logic [WORD_LEN-1:0] START_ADDR = 32'h0000_1000;

  // addi x0, x0, 0 -- returned for fetches outside the memory window.
  localparam logic [WORD_LEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IB_LOAD  = 2'd0,
    IB_DRAIN = 2'd1,
    IB_RUN   = 2'd2
  } ib_state_e;

endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-port synchronous RAM, one shared read/write address.
// Ports:
//   clk   - clock
//   we    - write enable
//   addr  - word address (write address while loading, read address in RUN)
//   wdata - write data
//   rdata - registered read data (read-before-write on the shared port)
module imem_ram
  import imem_boot_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [WORD_LEN-1:0]            wdata,
  output logic [WORD_LEN-1:0]            rdata
);

  logic [WORD_LEN-1:0] r_mem [DEPTH_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/imem_boot.sv
// imem_boot: instruction memory with a byte-serial boot loader.
// Bytes arrive little-endian, are packed into 32-bit words and written from
// word 0 upward; the core is held in reset (busy) until the last byte, after
// which instruction fetches are served with one-cycle latency.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   addr_i / inst  - core byte fetch address / registered instruction
//   load_valid, load_byte, load_last, load_ready - boot byte stream
//   busy           - high until RUN (core rst_n = !busy)
//   load_done      - one-cycle pulse on entry to RUN
//   load_err       - sticky overflow flag
module imem_boot
  import imem_boot_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] addr_i,
  output logic [WORD_LEN-1:0] inst,
  input  logic                load_valid,
  input  logic [7:0]          load_byte,
  input  logic                load_last,
  output logic                load_ready,
  output logic                busy,
  output logic                load_done,
  output logic                load_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  ib_state_e           r_state;
  ib_state_e           w_state_nx;
  logic [1:0]          r_byte_cnt;
  logic [AW-1:0]       r_word_ptr;
  logic [WORD_LEN-1:0] r_acc;
  logic                r_load_done;
  logic                r_load_err;
  logic                r_rd_run;
  logic                r_rd_in_range;

  logic                w_accept;
  logic                w_we;
  logic                w_err_set;
  logic [WORD_LEN-1:0] w_wdata;
  logic [WORD_LEN-1:0] w_rdata;
  logic [29:0]         w_widx;
  logic                w_in_range;
  logic [AW-1:0]       w_ram_addr;

  assign load_ready = (r_state == IB_LOAD) || (r_state == IB_DRAIN);
  assign busy       = (r_state != IB_RUN);
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;
  assign w_accept   = load_valid && load_ready;

  // Current byte merged into its lane; upper lanes of r_acc are still zero.
  assign w_wdata = r_acc | (WORD_LEN'(load_byte) << {r_byte_cnt, 3'b000});

  // Fetch window decode; the range test ignores addr_i[1:0].
  assign w_widx     = 30'((addr_i - START_ADDR) >> 2);
  assign w_in_range = (addr_i >= START_ADDR) && (w_widx < 30'(DEPTH_WORDS));
  assign w_ram_addr = (r_state == IB_RUN) ? w_widx[AW-1:0] : r_word_ptr;

  imem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (w_we),
    .addr (w_ram_addr),
    .wdata(w_wdata),
    .rdata(w_rdata)
  );

  // Read data and the range flag were captured on the same edge, so the NOP
  // substitution lines up with the RAM's one-cycle latency.
  assign inst = r_rd_run ? (r_rd_in_range ? w_rdata : INST_NOP) : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IB_LOAD;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state, RAM write strobe and overflow detection.
  always_comb begin
    w_state_nx = r_state;
    w_we       = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      IB_LOAD: begin
        if (w_accept) begin
          w_we = (r_byte_cnt == 2'd3) || load_last;
          if (load_last) begin
            w_state_nx = IB_RUN;
          end else if ((r_byte_cnt == 2'd3) && (r_word_ptr == AW'(DEPTH_WORDS - 1))) begin
            w_state_nx = IB_DRAIN;
            w_err_set  = 1'b1;
          end
        end
      end
      IB_DRAIN: begin
        if (w_accept && load_last) begin
          w_state_nx = IB_RUN;
        end
      end
      IB_RUN: begin
        w_state_nx = IB_RUN;
      end
      default: begin
        w_state_nx = IB_LOAD;
      end
    endcase
  end

  // Datapath: byte packing, write pointer, flags and read-side pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt    <= '0;
      r_word_ptr    <= '0;
      r_acc         <= '0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
      r_rd_run      <= 1'b0;
      r_rd_in_range <= 1'b0;
    end else begin
      r_load_done   <= (w_state_nx == IB_RUN) && (r_state != IB_RUN);
      r_load_err    <= r_load_err | w_err_set;
      r_rd_run      <= (r_state == IB_RUN);
      r_rd_in_range <= w_in_range;
      if ((r_state == IB_LOAD) && w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (w_we) begin
          r_acc      <= '0;
          r_word_ptr <= r_word_ptr + AW'(1);
        end else begin
          r_acc <= w_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot.sv
// tb_imem_boot: randomized self-checking bench for imem_boot with a
// word-array reference model of the loaded program.
module tb_imem_boot;
  import imem_boot_pkg::*;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_i = '0;
  logic [31:0] inst;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [D];
  bit          model_vld [D];

  always #5 clk = ~clk;

  imem_boot #(.DEPTH_WORDS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (addr_i),
    .inst      (inst),
    .load_valid(load_valid),
    .load_byte (load_byte),
    .load_last (load_last),
    .load_ready(load_ready),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (longint'(a) >= longint'(START_ADDR)) &&
           (longint'(a) < longint'(START_ADDR) + 4 * longint'(D));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - START_ADDR) / 4);
  endfunction

  function automatic bit known(input logic [31:0] a);
    if (!in_rng(a)) return 1'b1;
    return model_vld[widx(a)];
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    if (!in_rng(a)) return INST_NOP;
    return model_mem[widx(a)];
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(9, 0))
      0:       return START_ADDR - 32'($urandom_range(64, 1));
      1:       return START_ADDR + 32'(4 * D) + 32'($urandom_range(64, 0));
      default: return START_ADDR + 32'($urandom_range(4 * D - 1, 0));
    endcase
  endfunction

  task automatic do_reset();
    load_valid = 1'b0;
    load_last  = 1'b0;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Streams q; the model writes each completed (or last, zero-padded) word
  // and drops everything past 4*D bytes.
  task automatic load_prog(input logic [7:0] q[$], input bit send_last,
                           input int unsigned gmin, input int unsigned gmax);
    logic [31:0] acc;
    bit          is_last;
    bit          err_exp;
    int          n;
    acc = '0;
    n   = q.size();
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b0;
      repeat ($urandom_range(gmax, gmin)) begin
        @(posedge clk); #1;
      end
      is_last    = send_last && (i == n - 1);
      load_valid = 1'b1;
      load_byte  = q[i];
      load_last  = is_last;
      @(posedge clk); #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
      load_byte  = 8'($urandom);
      if (i < 4 * D) begin
        acc |= 32'(q[i]) << (8 * (i % 4));
        if ((i % 4 == 3) || is_last) begin
          model_mem[i / 4] = acc;
          model_vld[i / 4] = 1'b1;
          acc = '0;
        end
      end
      err_exp = (i + 1 > 4 * D) || ((i + 1 == 4 * D) && !is_last);
      chk("load_err", 32'(load_err), 32'(err_exp));
      chk("busy", 32'(busy), 32'(!is_last));
      chk("load_ready", 32'(load_ready), 32'(!is_last));
      chk("load_done", 32'(load_done), 32'(is_last));
      if (is_last) begin
        chk("inst_first_run", inst, 32'h0);
        @(posedge clk); #1;
        chk("load_done_fall", 32'(load_done), 32'h0);
        chk("load_err_hold", 32'(load_err), 32'(err_exp));
      end
    end
  endtask

  task automatic read_one(input logic [31:0] a, input string tag);
    addr_i = a;
    @(posedge clk); #1;
    if (known(a)) chk(tag, inst, exp_inst(a));
  endtask

  // Random fetches with garbage on the load port, which RUN must ignore.
  task automatic read_burst(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a          = rand_addr();
      addr_i     = a;
      load_valid = 1'($urandom);
      load_byte  = 8'($urandom);
      load_last  = 1'($urandom);
      @(posedge clk); #1;
      if (known(a)) chk("run_read", inst, exp_inst(a));
      chk("run_ready", 32'(load_ready), 32'h0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  function automatic void rand_prog(output logic [7:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] p[$];
    for (int i = 0; i < int'(D); i++) model_vld[i] = 1'b0;

    // Reset state.
    do_reset();
    chk("rst_inst", inst, 32'h0);
    chk("rst_done", 32'(load_done), 32'h0);
    chk("rst_err", 32'(load_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_ready", 32'(load_ready), 32'h1);

    // Two full words, back to back.
    q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load_prog(q, 1'b1, 0, 0);
    read_one(START_ADDR + 32'd4, "t1_w1");
    chk("t1_w1_const", inst, 32'h0010_0093);
    read_one(START_ADDR, "t1_w0");
    chk("t1_w0_const", inst, 32'h0000_0013);
    read_one(START_ADDR + 32'(4 * D), "t1_above");
    chk("t1_above_const", inst, INST_NOP);
    read_one(START_ADDR + 32'd6, "t1_unaligned");
    chk("t1_unaligned_const", inst, 32'h0010_0093);
    read_one(START_ADDR - 32'd4, "t1_below");
    chk("t1_below_const", inst, INST_NOP);

    // Partial final word is zero-padded.
    do_reset();
    q = '{8'hAA, 8'hBB, 8'hCC};
    load_prog(q, 1'b1, 0, 0);
    read_one(START_ADDR, "t2_w0");
    chk("t2_w0_const", inst, 32'h00CC_BBAA);

    // Overflow: 17 bytes into 4 words.
    do_reset();
    rand_prog(q, 17);
    load_prog(q, 1'b1, 0, 2);
    for (int k = 0; k < int'(D); k++) read_one(START_ADDR + 32'(4 * k), "t3_word");
    read_one(START_ADDR + 32'd12, "t3_w3");
    chk("t3_w3_const", inst, {q[15], q[14], q[13], q[12]});
    read_burst(20);
    chk("t3_err_sticky", 32'(load_err), 32'h1);

    // Exact full fill is legal.
    do_reset();
    chk("t4_err_cleared", 32'(load_err), 32'h0);
    rand_prog(q, 16);
    load_prog(q, 1'b1, 0, 1);
    read_burst(20);

    // Reset in the middle of a load.
    do_reset();
    rand_prog(q, 6);
    load_prog(q, 1'b0, 0, 1);
    do_reset();
    chk("t5_busy", 32'(busy), 32'h1);
    chk("t5_ready", 32'(load_ready), 32'h1);
    rand_prog(q, 4);
    load_prog(q, 1'b1, 0, 0);
    read_one(START_ADDR, "t5_w0");
    chk("t5_w0_const", inst, {q[3], q[2], q[1], q[0]});
    read_burst(12);

    // Same program with and without input gaps.
    rand_prog(p, 11);
    do_reset();
    load_prog(p, 1'b1, 0, 0);
    read_burst(16);
    do_reset();
    load_prog(p, 1'b1, 3, 3);
    for (int k = 0; k < int'(D); k++) read_one(START_ADDR + 32'(4 * k + 1), "t6_word");
    read_burst(16);

    // Random programs.
    for (int it = 0; it < 12; it++) begin
      do_reset();
      rand_prog(q, $urandom_range(20, 1));
      load_prog(q, 1'b1, 0, 2);
      read_burst(16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
